fpu_stream_shell: RTL and testbench

// - Parametrised issue/retire shell between a core-side valid/ready stream and a fixed-latency FP datapath (fpu_core class).
// - Registers operands, tracks in-flight ops with tags, buffers results in an output FIFO and accumulates exception flags.
// - Successor of the stall-only operand-register wrapper: adds full backpressure, tagging and configurable depth/latency.

---
 rtl/fpu_stream_shell.sv | 182 ++++++++++++++++++
 tb/tb_fpu_stream_shell.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_stream_shell.sv
`default_nettype none
// ============================================================================
// Module   : fpu_stream_shell
// Purpose  : Issue/retire shell between a valid/ready request stream and a
//            fixed-latency FP datapath. Operands are registered and issued
//            with a one-cycle enable strobe. A valid+tag pipe follows each op
//            through the datapath. Results land in a power-of-two FIFO.
//            Credit-based admission means the FIFO can never overflow.
// Option   : FPU_SHELL_STICKY_FLAGS_EN adds a sticky exception-flag register.
//            That register is set by every popped result and cleared by
//            Flags_Clr_SI.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_stream_shell #(
  parameter int WIDTH     = 32,
  parameter int RM_W      = 3,
  parameter int CMD_W     = 4,
  parameter int TAG_W     = 4,
  parameter int FLAG_W    = 6,
  parameter int CORE_LAT  = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic              In_Valid_SI,
  output logic              In_Ready_SO,
  input  logic [WIDTH-1:0]  Operand_a_DI,
  input  logic [WIDTH-1:0]  Operand_b_DI,
  input  logic [RM_W-1:0]   RM_SI,
  input  logic [CMD_W-1:0]  OP_SI,
  input  logic [TAG_W-1:0]  Tag_DI,
  output logic [WIDTH-1:0]  Core_Operand_a_DO,
  output logic [WIDTH-1:0]  Core_Operand_b_DO,
  output logic [RM_W-1:0]   Core_RM_SO,
  output logic [CMD_W-1:0]  Core_OP_SO,
  output logic              Core_Enable_SO,
  input  logic [WIDTH-1:0]  Core_Result_DI,
  input  logic [FLAG_W-1:0] Core_Flags_DI,
  output logic              Out_Valid_SO,
  input  logic              Out_Ready_SI,
  output logic [WIDTH-1:0]  Result_DO,
  output logic [FLAG_W-1:0] Flags_DO,
  output logic [TAG_W-1:0]  Tag_DO,
  input  logic              Flags_Clr_SI,
  output logic [FLAG_W-1:0] Flags_Sticky_DO
);

  localparam int            c_PTR_W  = $clog2(OUT_DEPTH);
  localparam int            c_STAGES = CORE_LAT + 1;
  localparam logic [c_PTR_W:0] c_CNT_MAX = (c_PTR_W+1)'(OUT_DEPTH);
  localparam logic [c_PTR_W:0] c_ONE     = (c_PTR_W+1)'(1);

  logic w_accept;
  logic w_pop;
  logic w_wr;

  logic [WIDTH-1:0]  opa_q, opb_q;
  logic [RM_W-1:0]   rm_q;
  logic [CMD_W-1:0]  op_q;
  logic              en_q;

  logic [c_STAGES-1:0] vld_q;
  logic [TAG_W-1:0]    tag_q [c_STAGES];

  logic [WIDTH-1:0]  res_mem_q  [OUT_DEPTH];
  logic [FLAG_W-1:0] flag_mem_q [OUT_DEPTH];
  logic [TAG_W-1:0]  tag_mem_q  [OUT_DEPTH];
  logic [c_PTR_W:0]  wr_ptr_q, rd_ptr_q;
  logic [c_PTR_W:0]  cnt_q, cnt_d;

  // Admission depends on registered credit only, so Out_Ready_SI never
  // reaches In_Ready_SO combinationally.
  assign In_Ready_SO  = (cnt_q < c_CNT_MAX);
  assign w_accept     = In_Valid_SI & In_Ready_SO;
  assign Out_Valid_SO = (wr_ptr_q != rd_ptr_q);
  assign w_pop        = Out_Valid_SO & Out_Ready_SI;
  // The last tracker stage lines up with the datapath result being valid.
  assign w_wr         = vld_q[c_STAGES-1];

  assign Core_Operand_a_DO = opa_q;
  assign Core_Operand_b_DO = opb_q;
  assign Core_RM_SO        = rm_q;
  assign Core_OP_SO        = op_q;
  assign Core_Enable_SO    = en_q;

  assign Result_DO = res_mem_q[rd_ptr_q[c_PTR_W-1:0]];
  assign Flags_DO  = flag_mem_q[rd_ptr_q[c_PTR_W-1:0]];
  assign Tag_DO    = tag_mem_q[rd_ptr_q[c_PTR_W-1:0]];

  // Operand register: loads on accept, holds otherwise; strobe for one cycle.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      opa_q <= '0;
      opb_q <= '0;
      rm_q  <= '0;
      op_q  <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= w_accept;
      if (w_accept) begin
        opa_q <= Operand_a_DI;
        opb_q <= Operand_b_DI;
        rm_q  <= RM_SI;
        op_q  <= OP_SI;
      end
    end
  end

  // In-flight tracker: valid bit and tag ride alongside the datapath.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      vld_q <= '0;
      for (int i = 0; i < c_STAGES; i++) tag_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[c_STAGES-2:0], w_accept};
      tag_q[0] <= Tag_DI;
      for (int i = 1; i < c_STAGES; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Result FIFO: extra pointer bit distinguishes full from empty.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        res_mem_q[i]  <= '0;
        flag_mem_q[i] <= '0;
        tag_mem_q[i]  <= '0;
      end
    end else begin
      if (w_wr) begin
        res_mem_q[wr_ptr_q[c_PTR_W-1:0]]  <= Core_Result_DI;
        flag_mem_q[wr_ptr_q[c_PTR_W-1:0]] <= Core_Flags_DI;
        tag_mem_q[wr_ptr_q[c_PTR_W-1:0]]  <= tag_q[c_STAGES-1];
        wr_ptr_q <= wr_ptr_q + c_ONE;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + c_ONE;
    end
  end

  // Credit: counts ops in flight plus ops buffered in the FIFO.
  always_comb begin
    cnt_d = cnt_q;
    case ({w_accept, w_pop})
      2'b10:   cnt_d = cnt_q + c_ONE;
      2'b01:   cnt_d = cnt_q - c_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

`ifdef FPU_SHELL_STICKY_FLAGS_EN
  logic [FLAG_W-1:0] sticky_q, sticky_d;

  // Clear takes effect before the popped flags are merged in.
  always_comb begin
    sticky_d = sticky_q;
    if (Flags_Clr_SI) sticky_d = '0;
    if (w_pop)        sticky_d = sticky_d | Flags_DO;
  end

  // Sticky flag register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) sticky_q <= '0;
    else          sticky_q <= sticky_d;
  end

  assign Flags_Sticky_DO = sticky_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = Flags_Clr_SI;
  assign Flags_Sticky_DO  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_stream_shell.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_stream_shell
// Purpose  : Directed, table-driven bench for fpu_stream_shell. A stand-in
//            datapath returns a+b as the result and b[5:0] as the flags,
//            after CORE_LAT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_stream_shell;

  localparam int WIDTH     = 32;
  localparam int RM_W      = 3;
  localparam int CMD_W     = 4;
  localparam int TAG_W     = 4;
  localparam int FLAG_W    = 6;
  localparam int CORE_LAT  = 2;
  localparam int OUT_DEPTH = 4;

  logic              Clk_CI, Rst_RBI;
  logic              In_Valid_SI, In_Ready_SO;
  logic [WIDTH-1:0]  Operand_a_DI, Operand_b_DI;
  logic [RM_W-1:0]   RM_SI;
  logic [CMD_W-1:0]  OP_SI;
  logic [TAG_W-1:0]  Tag_DI;
  logic [WIDTH-1:0]  Core_Operand_a_DO, Core_Operand_b_DO;
  logic [RM_W-1:0]   Core_RM_SO;
  logic [CMD_W-1:0]  Core_OP_SO;
  logic              Core_Enable_SO;
  logic [WIDTH-1:0]  Core_Result_DI;
  logic [FLAG_W-1:0] Core_Flags_DI;
  logic              Out_Valid_SO, Out_Ready_SI;
  logic [WIDTH-1:0]  Result_DO;
  logic [FLAG_W-1:0] Flags_DO, Flags_Sticky_DO;
  logic [TAG_W-1:0]  Tag_DO;
  logic              Flags_Clr_SI;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [3:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [5:0]  fl;
  } vec_t;

  vec_t tbl [20];
  int   n_vec = 0;
  int   n_err = 0;

  fpu_stream_shell #(
    .WIDTH(WIDTH), .RM_W(RM_W), .CMD_W(CMD_W), .TAG_W(TAG_W),
    .FLAG_W(FLAG_W), .CORE_LAT(CORE_LAT), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .In_Valid_SI(In_Valid_SI), .In_Ready_SO(In_Ready_SO),
    .Operand_a_DI(Operand_a_DI), .Operand_b_DI(Operand_b_DI),
    .RM_SI(RM_SI), .OP_SI(OP_SI), .Tag_DI(Tag_DI),
    .Core_Operand_a_DO(Core_Operand_a_DO), .Core_Operand_b_DO(Core_Operand_b_DO),
    .Core_RM_SO(Core_RM_SO), .Core_OP_SO(Core_OP_SO), .Core_Enable_SO(Core_Enable_SO),
    .Core_Result_DI(Core_Result_DI), .Core_Flags_DI(Core_Flags_DI),
    .Out_Valid_SO(Out_Valid_SO), .Out_Ready_SI(Out_Ready_SI),
    .Result_DO(Result_DO), .Flags_DO(Flags_DO), .Tag_DO(Tag_DO),
    .Flags_Clr_SI(Flags_Clr_SI), .Flags_Sticky_DO(Flags_Sticky_DO)
  );

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  // Stand-in datapath: fixed CORE_LAT-cycle pipe.
  logic [WIDTH-1:0]  pr_q [CORE_LAT];
  logic [FLAG_W-1:0] pf_q [CORE_LAT];
  always @(posedge Clk_CI) begin
    pr_q[0] <= Core_Operand_a_DO + Core_Operand_b_DO;
    pf_q[0] <= Core_Operand_b_DO[5:0];
    for (int k = 1; k < CORE_LAT; k++) begin
      pr_q[k] <= pr_q[k-1];
      pf_q[k] <= pf_q[k-1];
    end
  end
  assign Core_Result_DI = pr_q[CORE_LAT-1];
  assign Core_Flags_DI  = pf_q[CORE_LAT-1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic sv(input int i, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] tag, input logic [31:0] res, input logic [5:0] fl);
    tbl[i].a   = a;
    tbl[i].b   = b;
    tbl[i].rm  = 3'(i);
    tbl[i].op  = 4'(i + 1);
    tbl[i].tag = tag;
    tbl[i].res = res;
    tbl[i].fl  = fl;
  endtask

  task automatic drive(input int i);
    In_Valid_SI  = 1'b1;
    Operand_a_DI = tbl[i].a;
    Operand_b_DI = tbl[i].b;
    RM_SI        = tbl[i].rm;
    OP_SI        = tbl[i].op;
    Tag_DI       = tbl[i].tag;
  endtask

  function automatic logic [63:0] exp_of(input int i);
    return {22'b0, tbl[i].res, tbl[i].fl, tbl[i].tag};
  endfunction

  function automatic logic [63:0] head();
    return {22'b0, Result_DO, Flags_DO, Tag_DO};
  endfunction

  // Issue n table entries from 'first', holding Out_Ready low for 'hold'
  // cycles, and compare every popped result in order.
  task automatic stream(input int first, input int n, input int hold);
    int   issued;
    int   popped;
    logic acc;
    issued = 0;
    popped = 0;
    for (int cyc = 0; cyc < 200 && popped < n; cyc++) begin
      if (issued < n) drive(first + issued);
      else            In_Valid_SI = 1'b0;
      Out_Ready_SI = (cyc >= hold);
      // Round trip accept->pop is CORE_LAT+2 edges, so OUT_DEPTH=4 credits
      // are spent just before the first pop.
      if (hold == 0 && n > OUT_DEPTH && cyc == OUT_DEPTH) begin
        chk("credit_limit_issued", 64'(issued), 64'(OUT_DEPTH));
        chk("credit_limit_ready", 64'(In_Ready_SO), 64'd0);
      end
      if (hold > 0 && cyc < hold && Out_Valid_SO)
        chk("bp_head_stable", head(), exp_of(first));
      if (hold > 0 && cyc == hold - 1) begin
        chk("bp_accepted", 64'(issued), 64'(OUT_DEPTH));
        chk("bp_in_ready_low", 64'(In_Ready_SO), 64'd0);
        chk("bp_head_valid", 64'(Out_Valid_SO), 64'd1);
      end
      if (hold > 0 && cyc == hold + 1) begin
        chk("pop_no_accept", 64'(issued), 64'(OUT_DEPTH));
        chk("ready_back", 64'(In_Ready_SO), 64'd1);
      end
      acc = In_Valid_SI & In_Ready_SO;
      if (Out_Valid_SO && Out_Ready_SI) begin
        chk($sformatf("out[%0d]", first + popped), head(), exp_of(first + popped));
        popped++;
      end
      step();
      if (acc) issued++;
    end
    In_Valid_SI  = 1'b0;
    Out_Ready_SI = 1'b1;
    chk("out_count", 64'(popped), 64'(n));
    chk("drained", 64'(Out_Valid_SO), 64'd0);
  endtask

  initial begin
    int n_stale;
    //  idx  a              b              tag    a+b            b[5:0]
    sv(0,  32'h0000_0010, 32'h0000_0005, 4'h3, 32'h0000_0015, 6'b000101);
    sv(1,  32'h0000_0100, 32'h0000_0001, 4'h0, 32'h0000_0101, 6'b000001);
    sv(2,  32'h0000_0200, 32'h0000_0002, 4'h1, 32'h0000_0202, 6'b000010);
    sv(3,  32'h0000_0300, 32'h0000_0003, 4'h2, 32'h0000_0303, 6'b000011);
    sv(4,  32'h0000_0400, 32'h0000_0004, 4'h3, 32'h0000_0404, 6'b000100);
    sv(5,  32'h0000_0500, 32'h0000_0008, 4'h4, 32'h0000_0508, 6'b001000);
    sv(6,  32'h0000_0600, 32'h0000_0010, 4'h5, 32'h0000_0610, 6'b010000);
    sv(7,  32'h0000_0700, 32'h0000_0020, 4'h6, 32'h0000_0720, 6'b100000);
    sv(8,  32'hFFFF_FFFF, 32'h0000_0001, 4'h7, 32'h0000_0000, 6'b000001);
    sv(9,  32'h1234_0000, 32'h0000_5678, 4'h9, 32'h1234_5678, 6'b111000);
    sv(10, 32'hA000_0000, 32'h0A00_0000, 4'hA, 32'hAA00_0000, 6'b000000);
    sv(11, 32'h0000_00F0, 32'h0000_000F, 4'hB, 32'h0000_00FF, 6'b001111);
    sv(12, 32'h8000_0000, 32'h8000_0000, 4'hC, 32'h0000_0000, 6'b000000);
    sv(13, 32'h0000_0001, 32'h0000_003F, 4'hD, 32'h0000_0040, 6'b111111);
    sv(14, 32'h0000_0000, 32'h0000_0004, 4'hE, 32'h0000_0004, 6'b000100);
    sv(15, 32'h0000_0000, 32'h0000_0010, 4'hF, 32'h0000_0010, 6'b010000);
    sv(16, 32'h0000_0000, 32'h0000_0001, 4'h1, 32'h0000_0001, 6'b000001);
    sv(17, 32'h0000_0002, 32'h0000_0002, 4'h2, 32'h0000_0004, 6'b000010);
    sv(18, 32'h0000_0003, 32'h0000_0003, 4'h4, 32'h0000_0006, 6'b000011);
    sv(19, 32'h0000_0007, 32'h0000_0007, 4'h5, 32'h0000_000E, 6'b000111);

    Rst_RBI      = 1'b0;
    In_Valid_SI  = 1'b0;
    Operand_a_DI = '0;
    Operand_b_DI = '0;
    RM_SI        = '0;
    OP_SI        = '0;
    Tag_DI       = '0;
    Out_Ready_SI = 1'b1;
    Flags_Clr_SI = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(In_Ready_SO), 64'd1);
    chk("rst_out_valid", 64'(Out_Valid_SO), 64'd0);
    chk("rst_enable", 64'(Core_Enable_SO), 64'd0);
    chk("rst_sticky", 64'(Flags_Sticky_DO), 64'd0);
    Rst_RBI = 1'b1;
    step();

    // Single op: accept at edge 0, enable in cycle 1, result after edge 3.
    drive(0);
    step();
    In_Valid_SI = 1'b0;
    chk("single_enable_hi", 64'(Core_Enable_SO), 64'd1);
    chk("single_core_a", 64'(Core_Operand_a_DO), 64'(tbl[0].a));
    chk("single_core_b", 64'(Core_Operand_b_DO), 64'(tbl[0].b));
    chk("single_core_rm_op", 64'({Core_RM_SO, Core_OP_SO}), 64'({tbl[0].rm, tbl[0].op}));
    step();
    chk("single_enable_lo", 64'(Core_Enable_SO), 64'd0);
    chk("single_no_early_1", 64'(Out_Valid_SO), 64'd0);
    step();
    chk("single_no_early_2", 64'(Out_Valid_SO), 64'd0);
    step();
    chk("single_valid", 64'(Out_Valid_SO), 64'd1);
    chk("single_head", head(), exp_of(0));
    step();
    chk("single_one_cycle", 64'(Out_Valid_SO), 64'd0);

    // Back-to-back tags 0..7 with consumer always ready.
    stream(1, 8, 0);

    // Backpressure to full, then pop-while-full and refill.
    stream(9, 6, 12);

    // Sticky flags.
    Flags_Clr_SI = 1'b1;
    step();
    Flags_Clr_SI = 1'b0;
    chk("sticky_cleared", 64'(Flags_Sticky_DO), 64'd0);
    stream(14, 2, 0);
`ifdef FPU_SHELL_STICKY_FLAGS_EN
    chk("sticky_accum", 64'(Flags_Sticky_DO), 64'(6'b010100));
    Out_Ready_SI = 1'b0;
    drive(16);
    step();
    In_Valid_SI = 1'b0;
    for (int i = 0; i < 10 && !Out_Valid_SO; i++) step();
    chk("sticky_pop_valid", 64'(Out_Valid_SO), 64'd1);
    chk("sticky_pop_head", head(), exp_of(16));
    Flags_Clr_SI = 1'b1;
    Out_Ready_SI = 1'b1;
    step();
    Flags_Clr_SI = 1'b0;
    chk("sticky_clr_and_pop", 64'(Flags_Sticky_DO), 64'(6'b000001));
`else
    chk("sticky_tied_zero", 64'(Flags_Sticky_DO), 64'd0);
`endif

    // Reset with three ops in flight: nothing stale may appear afterwards.
    Out_Ready_SI = 1'b1;
    drive(17);
    step();
    drive(18);
    step();
    drive(19);
    step();
    In_Valid_SI = 1'b0;
    Rst_RBI = 1'b0;
    #2;
    chk("midrst_out_valid", 64'(Out_Valid_SO), 64'd0);
    chk("midrst_in_ready", 64'(In_Ready_SO), 64'd1);
    chk("midrst_enable", 64'(Core_Enable_SO), 64'd0);
    step();
    Rst_RBI = 1'b1;
    n_stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (Out_Valid_SO) n_stale++;
      step();
    end
    chk("midrst_no_stale", 64'(n_stale), 64'd0);
    chk("midrst_ready_after", 64'(In_Ready_SO), 64'd1);
    stream(19, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
